// File: rtl/spi_master_rx_fifo.sv
// Receive word FIFO between the SPI RX shifter and the register/bus side; push-to-pop latency 1 cycle.
// ready_o/valid_o decode from the registered fill count only, so a full FIFO stalls the shifter without loss.
module spi_master_rx_fifo #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 8,
  localparam int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr_i,
  input  logic [LOG_BUFFER_DEPTH:0]   thresh_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  output logic                        thresh_o
);

  localparam logic [LOG_BUFFER_DEPTH:0]   FULL_COUNT = (LOG_BUFFER_DEPTH+1)'(BUFFER_DEPTH);
  localparam logic [LOG_BUFFER_DEPTH:0]   CNT_ONE    = (LOG_BUFFER_DEPTH+1)'(1);
  localparam logic [LOG_BUFFER_DEPTH-1:0] PTR_ONE    = LOG_BUFFER_DEPTH'(1);

  logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0] wr_ptr;
  logic [LOG_BUFFER_DEPTH-1:0] rd_ptr;
  logic [LOG_BUFFER_DEPTH:0]   elements;
  logic                        push;
  logic                        pop;

  // Handshake outputs must never see valid_i/ready_i: the shifter closes a loop through ready_o.
  assign ready_o = (elements != FULL_COUNT);
  assign valid_o = (elements != '0);

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      elements <= '0;
    end else if (clr_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      elements <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   elements <= elements + CNT_ONE;
        2'b01:   elements <= elements - CNT_ONE;
        default: elements <= elements;
      endcase
    end
  end

  // Storage is deliberately left unreset; the counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && rstn && !clr_i) mem[wr_ptr] <= data_i;
  end

  assign data_o     = valid_o ? mem[rd_ptr] : '0;
  assign elements_o = elements;
  assign thresh_o   = (thresh_i != '0) && (elements >= thresh_i);

endmodule

// File: tb/tb_spi_master_rx_fifo.sv
// Randomized and directed bench for spi_master_rx_fifo against a queue-based reference model.
module tb_spi_master_rx_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr_i = 1'b0;
  logic [3:0]  thresh_i = '0;
  logic [31:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [3:0]  elements_o;
  logic        thresh_o;

  int checks = 0;
  int passed = 0;
  logic [31:0] q[$];

  spi_master_rx_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .clr_i(clr_i), .thresh_i(thresh_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .elements_o(elements_o), .thresh_o(thresh_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock it, and advance the reference queue.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c, input logic rs);
    logic acc, pp;
    valid_i = v; data_i = d; ready_i = r; clr_i = c; rstn = rs;
    acc = v && (q.size() < DEPTH);
    pp  = r && (q.size() > 0);
    @(posedge clk); #1;
    if (!rs || c) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    valid_i = 1'b0; ready_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic test_reset;
    thresh_i = 4'd3;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rstn = 1'b1; #1;
    checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_o); else passed++;
    checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else passed++;
    checks++; if (data_o !== 32'h0) $display("FAIL reset_data got=%h exp=0", data_o); else passed++;
    checks++; if (elements_o !== 4'd0) $display("FAIL reset_elems got=%0d exp=0", elements_o); else passed++;
    checks++; if (thresh_o !== 1'b0) $display("FAIL reset_thresh got=%b exp=0", thresh_o); else passed++;
  endtask

  task automatic test_order;
    logic [31:0] w [3];
    w[0] = 32'hA5A5_0001; w[1] = 32'hA5A5_0002; w[2] = 32'hA5A5_0003;
    thresh_i = 4'd0;
    step(1, w[0], 0, 0, 1);
    checks++; if (data_o !== w[0] || valid_o !== 1'b1)
      $display("FAIL order_first got=%h/%b exp=%h/1", data_o, valid_o, w[0]); else passed++;
    step(1, w[1], 0, 0, 1);
    step(1, w[2], 0, 0, 1);
    checks++; if (elements_o !== 4'd3) $display("FAIL order_elems got=%0d exp=3", elements_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_o !== w[i]) $display("FAIL order_pop%0d got=%h exp=%h", i, data_o, w[i]); else passed++;
      step(0, 0, 1, 0, 1);
    end
    checks++; if (valid_o !== 1'b0 || data_o !== 32'h0)
      $display("FAIL order_empty got=%b/%h exp=0/0", valid_o, data_o); else passed++;
  endtask

  task automatic test_full;
    for (int i = 0; i < DEPTH; i++) step(1, 32'(i), 0, 0, 1);
    checks++; if (elements_o !== 4'd8 || ready_o !== 1'b0)
      $display("FAIL full_level got=%0d/%b exp=8/0", elements_o, ready_o); else passed++;
    checks++; if (data_o !== 32'h0) $display("FAIL full_head got=%h exp=0", data_o); else passed++;
    step(1, 32'h8, 1, 0, 1);
    checks++; if (elements_o !== 4'd7 || ready_o !== 1'b1 || data_o !== 32'h1)
      $display("FAIL full_pop got=%0d/%b/%h exp=7/1/1", elements_o, ready_o, data_o); else passed++;
    step(1, 32'h8, 0, 0, 1);
    checks++; if (elements_o !== 4'd8 || ready_o !== 1'b0)
      $display("FAIL full_refill got=%0d/%b exp=8/0", elements_o, ready_o); else passed++;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (data_o !== 32'(i)) $display("FAIL full_drain%0d got=%h exp=%h", i, data_o, 32'(i)); else passed++;
      step(0, 0, 1, 0, 1);
    end
    checks++; if (elements_o !== 4'd0) $display("FAIL full_drained got=%0d exp=0", elements_o); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] sent[$];
    int n_out = 0;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom; sent.push_back(d); step(1, d, 0, 0, 1);
    end
    for (int i = 0; i < 20; i++) begin
      d = $urandom; sent.push_back(d);
      checks++; if (data_o !== sent[n_out])
        $display("FAIL b2b_data%0d got=%h exp=%h", i, data_o, sent[n_out]); else passed++;
      n_out++;
      step(1, d, 1, 0, 1);
      checks++; if (elements_o !== 4'd4) $display("FAIL b2b_elems%0d got=%0d exp=4", i, elements_o); else passed++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data_o !== sent[n_out])
        $display("FAIL b2b_tail%0d got=%h exp=%h", i, data_o, sent[n_out]); else passed++;
      n_out++;
      step(0, 0, 1, 0, 1);
    end
    checks++; if (valid_o !== 1'b0) $display("FAIL b2b_empty got=%b exp=0", valid_o); else passed++;
  endtask

  task automatic test_threshold;
    thresh_i = 4'd5;
    for (int i = 1; i <= 5; i++) begin
      step(1, $urandom, 0, 0, 1);
      checks++; if (thresh_o !== (i >= 5))
        $display("FAIL thr_rise%0d got=%b exp=%b", i, thresh_o, (i >= 5)); else passed++;
    end
    step(0, 0, 1, 0, 1);
    checks++; if (thresh_o !== 1'b0) $display("FAIL thr_fall got=%b exp=0", thresh_o); else passed++;
    thresh_i = 4'd0;
    for (int i = 0; i < 5; i++) begin
      step(1, $urandom, 0, 0, 1);
      checks++; if (thresh_o !== 1'b0) $display("FAIL thr_off%0d got=%b exp=0", i, thresh_o); else passed++;
    end
    step(0, 0, 0, 1, 1);
    checks++; if (elements_o !== 4'd0) $display("FAIL thr_clr got=%0d exp=0", elements_o); else passed++;
  endtask

  task automatic test_flush;
    for (int i = 0; i < 6; i++) step(1, 32'h100 + 32'(i), 0, 0, 1);
    checks++; if (elements_o !== 4'd6) $display("FAIL flush_pre got=%0d exp=6", elements_o); else passed++;
    step(1, 32'hDEAD_BEEF, 1, 1, 1);
    checks++; if (elements_o !== 4'd0 || valid_o !== 1'b0 || data_o !== 32'h0)
      $display("FAIL flush_state got=%0d/%b/%h exp=0/0/0", elements_o, valid_o, data_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 1);
      checks++; if (data_o === 32'hDEAD_BEEF || valid_o !== 1'b0)
        $display("FAIL flush_leak%0d got=%h/%b exp=0/0", i, data_o, valid_o); else passed++;
    end
  endtask

  task automatic test_random;
    logic [31:0] ed;
    int sz;
    for (int c = 0; c < 400; c++) begin
      thresh_i = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0);
      sz = q.size();
      ed = (sz > 0) ? q[0] : 32'h0;
      checks++; if (elements_o !== 4'(sz)) $display("FAIL rnd_elems c=%0d got=%0d exp=%0d", c, elements_o, sz); else passed++;
      checks++; if (data_o !== ed) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, data_o, ed); else passed++;
      checks++; if (ready_o !== (sz != DEPTH) || valid_o !== (sz != 0))
        $display("FAIL rnd_hs c=%0d got=%b/%b exp=%b/%b", c, ready_o, valid_o, sz != DEPTH, sz != 0); else passed++;
      checks++; if (thresh_o !== (thresh_i != 0 && sz >= int'(thresh_i)))
        $display("FAIL rnd_thr c=%0d got=%b exp=%b", c, thresh_o, (thresh_i != 0 && sz >= int'(thresh_i))); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_back_to_back();
    test_threshold();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
